dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port: it accepts `MemWrite`/`DataAdr`/`WriteData` transfers, inserts a configurable number of wait states, and commits the write or returns `ReadData` with a one-cycle `Ready` pulse. It sits between the processor core's data port and on-chip word RAM. It replaces the zero-latency combinational memory model so the core and its future stall logic can be exercised against realistic latency.

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 15 +
 rtl/dmem_responder_ram.sv | 17 +
 rtl/dmem_responder.sv | 90 +++++++++
 tb/tb_dmem_responder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-port bundle between the core (master) and the responder (slave).
interface dmem_if;
  logic        Req;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Err;

  modport master (output Req, MemWrite, DataAdr, WriteData,
                  input  ReadData, Ready, Err);
  modport slave  (input  Req, MemWrite, DataAdr, WriteData,
                  output ReadData, Ready, Err);
endinterface

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM, synchronous write, registered read (read-before-write).
module dmem_ram #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd
);
  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a transfer, waits WAIT_STATES cycles, accesses RAM, pulses Ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_WAIT   = 2'(WAIT);
  localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
  localparam logic [1:0] ST_RESP   = 2'(RESP);
  localparam int OFS = $clog2(WORD_BYTES);

  logic [1:0]            state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  we_q, mis_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wd_q;
  logic                  ready_q, err_q, rdsel_q;
  logic [31:0]           rdata_q, rdata_mux, ram_rd;
  logic                  ram_we;

  // Address bits above the word index alias and are intentionally dropped.
  logic unused_adr;
  assign unused_adr = ^{bus.DataAdr[31:ADDR_WIDTH+OFS]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdsel_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdsel_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.Req) begin
          we_q  <= bus.MemWrite;
          mis_q <= misaligned(bus.DataAdr[1:0]);
          idx_q <= bus.DataAdr[ADDR_WIDTH+OFS-1:OFS];
          wd_q  <= bus.WriteData;
          cnt   <= WAIT_CNT_W'(WAIT_STATES);
          state <= (WAIT_STATES != 0) ? ST_WAIT : ST_ACCESS;
        end
        ST_WAIT: begin
          cnt <= cnt - WAIT_CNT_W'(1);
          if (cnt == WAIT_CNT_W'(1)) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          state   <= ST_RESP;
          ready_q <= 1'b1;
          err_q   <= mis_q;
          rdsel_q <= !we_q && !mis_q;
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          rdata_q <= rdata_mux;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM word is only presented during a good read's RESP; otherwise hold or force zero.
  assign rdata_mux = rdsel_q ? ram_rd : (err_q ? 32'h0 : rdata_q);
  assign ram_we    = (state == ST_ACCESS) && we_q && !mis_q;

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (idx_q),
    .wd   (wd_q),
    .rd   (ram_rd)
  );

  assign bus.ReadData = rdata_mux;
  assign bus.Ready    = ready_q;
  assign bus.Err      = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int WS = 1;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  logic [31:0] mem [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one transfer from an idle negedge; returns response and checks latency/pulse width.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e);
    int n;
    bus.Req = 1'b1; bus.MemWrite = w; bus.DataAdr = a; bus.WriteData = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.Ready && n < 40);
    chk("latency", 32'(n), 32'(WS + 2));
    rd = bus.ReadData; e = bus.Err;
    bus.Req = 1'b0;
    @(negedge clk);
    chk("pulse_width", 32'(bus.Ready), 32'd0);
  endtask

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic e, mis;
    int idx;
    xfer(w, a, d, rd, e);
    mis = (a[1:0] != 2'b00);
    idx = int'((a >> 2) % (1 << AW));
    chk(w ? "wr_err" : "rd_err", 32'(e), 32'(mis));
    if (!w) begin
      if (mis) chk("rd_misalign_zero", rd, 32'h0);
      else if (mem.exists(idx)) chk("rd_data", rd, mem[idx]);
    end else if (!mis) mem[idx] = d;
  endtask

  task automatic xfer0(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
    int n;
    bus0.Req = 1'b1; bus0.MemWrite = w; bus0.DataAdr = a; bus0.WriteData = d;
    @(negedge clk);
    n = 1;
    bus0.Req = 1'b0;
    while (!bus0.Ready && n < 40) begin @(negedge clk); n++; end
    chk("ws0_latency", 32'(n), 32'd2);
    rd = bus0.ReadData; e = bus0.Err;
    @(negedge clk);
    chk("ws0_pulse_width", 32'(bus0.Ready), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic e;
    int pulses[$];
    int n;
    logic prev;

    reset = 1'b0;
    bus.Req = 1'b0; bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    bus0.Req = 1'b0; bus0.MemWrite = 1'b0; bus0.DataAdr = '0; bus0.WriteData = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.Ready), 32'd0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    chk("rst_rdata", bus.ReadData, 32'h0);
    chk("rst_ready0", 32'(bus0.Ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // directed cases
    op(1'b1, 32'h10, 32'hDEADBEEF);
    op(1'b0, 32'h10, 32'h0);
    op(1'b1, 32'h13, 32'hCAFEF00D);
    op(1'b0, 32'h13, 32'h0);
    op(1'b0, 32'h10, 32'h0);
    op(1'b1, 32'h100, 32'hA5A5A5A5);
    op(1'b0, 32'h000, 32'h0);
    op(1'b1, 32'h20, 32'h0);

    // continuous Req: three reads of 0x10
    bus.Req = 1'b1; bus.MemWrite = 1'b0; bus.DataAdr = 32'h10;
    n = 0; prev = 1'b0;
    while (pulses.size() < 3 && n < 60) begin
      @(negedge clk); n++;
      if (bus.Ready) begin
        pulses.push_back(n);
        chk("b2b_rdata", bus.ReadData, 32'hDEADBEEF);
        if (prev) chk("b2b_width", 32'd2, 32'd1);
      end
      prev = bus.Ready;
    end
    bus.Req = 1'b0;
    chk("b2b_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("b2b_gap1", 32'(pulses[1] - pulses[0]), 32'(WS + 3));
      chk("b2b_gap2", 32'(pulses[2] - pulses[1]), 32'(WS + 3));
    end
    @(negedge clk);
    chk("b2b_idle", 32'(bus.Ready), 32'd0);

    // reset during WAIT aborts the write
    bus.Req = 1'b1; bus.MemWrite = 1'b1; bus.DataAdr = 32'h20; bus.WriteData = 32'h12345678;
    @(negedge clk);
    reset = 1'b0;
    bus.Req = 1'b0;
    #1 chk("abort_ready", 32'(bus.Ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_ready_hold", 32'(bus.Ready), 32'd0);
    chk("abort_rdata", bus.ReadData, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    op(1'b0, 32'h20, 32'h0);

    // randomized traffic with aliasing and misalignment
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      op(1'($urandom_range(0, 1)), a, d);
    end

    // zero wait states, Req dropped right after acceptance
    d = $urandom;
    xfer0(1'b1, 32'h44, d, rd, e);
    chk("ws0_wr_err", 32'(e), 32'd0);
    xfer0(1'b0, 32'h44, 32'h0, rd, e);
    chk("ws0_rd_err", 32'(e), 32'd0);
    chk("ws0_rd_data", rd, d);
    xfer0(1'b0, 32'h46, 32'h0, rd, e);
    chk("ws0_mis_err", 32'(e), 32'd1);
    chk("ws0_mis_zero", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
